// File: rtl/mdc_fft_ctrl.sv
// Control sequencer for a radix-2 MDC FFT: commutator selects, stage strobes,
// frame sync and frame counting.
// Ports: clk, rst (async high); in_valid/in_sof in; clr_err in;
//        stage_en, sel, out_valid, out_sof, sync_err, frame_cnt out.
module mdc_fft_ctrl #(
  parameter int STAGES    = 4,
  parameter int STAGE_LAT = 1,
  parameter int FRAME_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic               clr_err,
  output logic [STAGES-1:0]  stage_en,
  output logic [STAGES-2:0]  sel,
  output logic               out_valid,
  output logic               out_sof,
  output logic               sync_err,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int IW = STAGES - 1;
  localparam int L  = STAGES * STAGE_LAT;

  logic [IW-1:0]        cnt;
  logic [IW-1:0]        idx0;
  logic                 resync;
  logic [L-1:0]         vp;
  logic [L-1:0]         sp;
  logic [L-1:0][IW-1:0] ip;
  logic [STAGES-2:0]    sel_q;

  // sof forces index 0; a mid-frame sof is a resync
  assign idx0   = in_sof ? '0 : cnt;
  assign resync = in_valid & in_sof & (cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      vp  <= '0;
      sp  <= '0;
      ip  <= '0;
    end else begin
      if (in_valid)
        cnt <= IW'(idx0 + 1'b1);
      vp[0] <= in_valid;
      sp[0] <= in_valid & (idx0 == '0);
      ip[0] <= idx0;
      for (int i = 1; i < L; i++) begin
        vp[i] <= vp[i-1];
        sp[i] <= sp[i-1];
        ip[i] <= ip[i-1];
      end
    end
  end

  assign stage_en[0] = in_valid;

  genvar k;
  for (k = 1; k < STAGES; k++) begin : g_en
    assign stage_en[k] = vp[k*STAGE_LAT-1];
  end

  // bubbles hold the commutator where it was
  for (k = 0; k < STAGES-1; k++) begin : g_sel
    if (k == 0) begin : g_s0
      assign sel[k] = stage_en[k] ? idx0[k] : sel_q[k];
    end else begin : g_sk
      assign sel[k] = stage_en[k] ? ip[k*STAGE_LAT-1][k] : sel_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sel_q <= '0;
    else
      sel_q <= sel;
  end

  assign out_valid = vp[L-1];
  assign out_sof   = sp[L-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (vp[L-1] && (ip[L-1] == '1)) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // set dominates clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sync_err <= 1'b0;
    else if (resync)
      sync_err <= 1'b1;
    else if (clr_err)
      sync_err <= 1'b0;
  end

endmodule

// File: tb/tb_mdc_fft_ctrl.sv
// Testbench for mdc_fft_ctrl: directed table of vectors plus
// hand-written multi-cycle sequences checked against a small reference model.
module tb_mdc_fft_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic        clr_err = 1'b0;
  logic [3:0]  stage_en;
  logic [2:0]  sel;
  logic        out_valid, out_sof, sync_err;
  logic [15:0] frame_cnt;
  logic [3:0]  stage_en2;
  logic [2:0]  sel2;
  logic        out_valid2, out_sof2, sync_err2;
  logic [1:0]  frame_cnt2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mdc_fft_ctrl #(.STAGES(4), .STAGE_LAT(1), .FRAME_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .clr_err(clr_err), .stage_en(stage_en), .sel(sel),
    .out_valid(out_valid), .out_sof(out_sof), .sync_err(sync_err),
    .frame_cnt(frame_cnt)
  );

  mdc_fft_ctrl #(.STAGES(4), .STAGE_LAT(1), .FRAME_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .clr_err(clr_err), .stage_en(stage_en2), .sel(sel2),
    .out_valid(out_valid2), .out_sof(out_sof2), .sync_err(sync_err2),
    .frame_cnt(frame_cnt2)
  );

  typedef struct {
    logic        r, v, s, c;
    logic [3:0]  en;
    logic [2:0]  sl;
    logic        ov, os, err;
    logic [15:0] fc;
  } vec_t;

  vec_t tab[18];

  function automatic vec_t mk(logic r, logic v, logic s, logic c,
                              logic [3:0] en, logic [2:0] sl,
                              logic ov, logic os, logic err,
                              logic [15:0] fc);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.c = c;
    t.en = en; t.sl = sl; t.ov = ov; t.os = os; t.err = err; t.fc = fc;
    return t;
  endfunction

  // reference model state
  logic       hv[1:4];
  logic [2:0] hi[1:4];
  logic [2:0] mcnt;
  logic [2:0] msel;
  logic       merr;
  logic [15:0] mfc;

  task automatic mclear();
    for (int i = 1; i <= 4; i++) begin
      hv[i] = 1'b0;
      hi[i] = 3'd0;
    end
    mcnt = 3'd0; msel = 3'd0; merr = 1'b0; mfc = 16'd0;
  endtask

  task automatic drive(input logic r, v, s, c);
    @(negedge clk);
    rst = r; in_valid = v; in_sof = s; clr_err = c;
    #2;
  endtask

  task automatic cmp(input string nm, input logic [3:0] een,
                     input logic [2:0] esel, input logic eov, eos, eerr,
                     input logic [15:0] efc);
    n_vec++;
    if ({stage_en, sel, out_valid, out_sof, sync_err, frame_cnt, frame_cnt2}
        !== {een, esel, eov, eos, eerr, efc, efc[1:0]}) begin
      n_bad++;
      $display("FAIL %s: got en=%b sel=%b ov=%b os=%b err=%b fc=%0d fc2=%0d want en=%b sel=%b ov=%b os=%b err=%b fc=%0d fc2=%0d",
               nm, stage_en, sel, out_valid, out_sof, sync_err, frame_cnt,
               frame_cnt2, een, esel, eov, eos, eerr, efc, efc[1:0]);
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  // one cycle through DUT and model
  task automatic step(input logic r, v, s, c, input string nm);
    logic [2:0] idx0, esel;
    logic [3:0] een;
    logic       set;
    drive(r, v, s, c);
    if (r) mclear();
    idx0 = s ? 3'd0 : mcnt;
    een  = {hv[3], hv[2], hv[1], v};
    esel[0] = v     ? idx0[0]  : msel[0];
    esel[1] = hv[1] ? hi[1][1] : msel[1];
    esel[2] = hv[2] ? hi[2][2] : msel[2];
    cmp(nm, een, esel, hv[4], hv[4] && hi[4] == 3'd0, merr, mfc);
    if (!r) begin
      set = v && s && mcnt != 3'd0;
      if (v) mcnt = idx0 + 3'd1;
      if (set) merr = 1'b1;
      else if (c) merr = 1'b0;
      if (hv[4] && hi[4] == 3'd7) mfc = mfc + 16'd1;
      msel = esel;
      for (int i = 4; i > 1; i--) begin
        hv[i] = hv[i-1];
        hi[i] = hi[i-1];
      end
      hv[1] = v;
      hi[1] = idx0;
    end
  endtask

  int nsof;

  initial begin
    tab[0]  = mk(1,0,0,0, 4'b0000, 3'b000, 0,0,0, 0);
    tab[1]  = mk(0,1,1,0, 4'b0001, 3'b000, 0,0,0, 0);
    tab[2]  = mk(0,1,0,0, 4'b0011, 3'b001, 0,0,0, 0);
    tab[3]  = mk(0,1,0,0, 4'b0111, 3'b000, 0,0,0, 0);
    tab[4]  = mk(0,1,0,0, 4'b1111, 3'b011, 0,0,0, 0);
    tab[5]  = mk(0,1,0,0, 4'b1111, 3'b010, 1,1,0, 0);
    tab[6]  = mk(0,1,0,0, 4'b1111, 3'b001, 1,0,0, 0);
    tab[7]  = mk(0,1,0,0, 4'b1111, 3'b100, 1,0,0, 0);
    tab[8]  = mk(0,1,0,0, 4'b1111, 3'b111, 1,0,0, 0);
    tab[9]  = mk(0,0,0,0, 4'b1110, 3'b111, 1,0,0, 0);
    tab[10] = mk(0,0,0,0, 4'b1100, 3'b111, 1,0,0, 0);
    tab[11] = mk(0,0,0,0, 4'b1000, 3'b111, 1,0,0, 0);
    tab[12] = mk(0,0,0,0, 4'b0000, 3'b111, 1,0,0, 0);
    tab[13] = mk(0,0,0,0, 4'b0000, 3'b111, 0,0,0, 1);
    // new frame starts, then reset lands mid-stream
    tab[14] = mk(0,1,1,0, 4'b0001, 3'b110, 0,0,0, 1);
    tab[15] = mk(1,1,0,0, 4'b0001, 3'b000, 0,0,0, 0);
    tab[16] = mk(0,0,0,0, 4'b0000, 3'b000, 0,0,0, 0);
    tab[17] = mk(0,0,0,0, 4'b0000, 3'b000, 0,0,0, 0);

    for (int i = 0; i < 18; i++) begin
      drive(tab[i].r, tab[i].v, tab[i].s, tab[i].c);
      cmp($sformatf("tab%0d", i), tab[i].en, tab[i].sl,
          tab[i].ov, tab[i].os, tab[i].err, tab[i].fc);
    end
    mclear();

    // sparse frame: valid every other cycle
    for (int i = 0; i < 8; i++) begin
      step(0, 1, i == 0, 0, "sparse_v");
      step(0, 0, 0, 0, "sparse_b");
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, "sparse_tail");
    chk("sparse_fc", frame_cnt, 1);

    // early sof on 6th pair
    for (int i = 0; i < 5; i++) step(0, 1, i == 0, 0, "sync_pre");
    step(0, 1, 1, 0, "sync_sof");
    step(0, 1, 0, 0, "sync_post");
    chk("sync_err_set", sync_err, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, "sync_rest");
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, "sync_tail");
    chk("sync_fc", frame_cnt, 2);
    step(0, 0, 0, 1, "clr");
    step(0, 0, 0, 0, "clr_after");
    chk("sync_err_clr", sync_err, 0);

    // set and clear together: set wins
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "setclr_pre");
    step(0, 1, 1, 1, "setclr");
    step(0, 0, 0, 0, "setclr_after");
    chk("setclr_err", sync_err, 1);
    step(0, 0, 0, 1, "setclr_clr");

    // back-to-back frames, sof only on first
    step(1, 0, 0, 0, "b2b_rst");
    nsof = 0;
    for (int i = 0; i < 26; i++) begin
      step(0, i < 16, i == 0, 0, "b2b");
      if (out_sof) nsof++;
    end
    chk("b2b_fc", frame_cnt, 2);
    chk("b2b_nsof", nsof, 2);

    // five frames, narrow counter wraps
    step(1, 0, 0, 0, "wrap_rst");
    for (int i = 0; i < 50; i++) step(0, i < 40, i == 0, 0, "wrap");
    chk("wrap_fc", frame_cnt, 5);
    chk("wrap_fc2", frame_cnt2, 1);

    // reset with pairs in flight
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "rst_pre");
    step(1, 1, 0, 0, "rst_mid");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, "rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mdc_fft_ctrl.md
MDC_FFT_CTRL -- requirements
Module: mdc_fft_ctrl

Interface
REQ-001 Parameter STAGES, default 4, meaning number of radix-2 stages; frame = 2^STAGES points = P = 2^(STAGES-1) sample pairs.
REQ-002 Parameter STAGE_LAT, default 1, meaning cycles of latency per datapath stage.
REQ-003 Parameter FRAME_W, default 16, meaning frame counter width.
REQ-004 Port clk  input  1  sole clock; all state on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port in_valid  input  1  a sample pair is presented to stage 0 this cycle.
REQ-007 Port in_sof  input  1  qualifies in_valid; pair is index 0 of a frame.
REQ-008 Port clr_err  input  1  clears sync_err.
REQ-009 Port stage_en  output  STAGES  per-stage valid strobe.
REQ-010 Port sel  output  STAGES-1  per-stage commutator swap select.
REQ-011 Port out_valid  output  1  pair leaving last stage is valid.
REQ-012 Port out_sof  output  1  leaving pair is index 0.
REQ-013 Port sync_err  output  1  sticky mid-frame sof flag.
REQ-014 Port frame_cnt  output  FRAME_W  count of completed frames.

Function
REQ-015 SHALL assign each accepted pair (in_valid=1) an index: 0 if in_sof=1, else the input pair counter value; counter then becomes index+1 modulo P.
REQ-016 in_sof with in_valid=0 SHALL be ignored.
REQ-017 After reset the input counter SHALL be 0, so the first frame needs no sof.
REQ-018 stage_en[k] SHALL equal in_valid delayed k*STAGE_LAT cycles (stage_en[0] = in_valid, combinational pass).
REQ-019 Each pair's index and sof SHALL travel with its valid through a shift pipeline, one tap per stage.
REQ-020 sel[k] SHALL equal bit k of the index of the pair at stage k while stage_en[k]=1 (stage 0 toggles every pair, stage k every 2^k pairs).
REQ-021 sel[k] SHALL hold its last value while stage_en[k]=0 (bubbles do not advance commutation).
REQ-022 out_valid/out_sof SHALL equal in_valid/(in_valid and index==0) delayed STAGES*STAGE_LAT cycles.
REQ-023 frame_cnt SHALL increment, wrapping at 2^FRAME_W, in the cycle after out_valid=1 with index P-1.
REQ-024 in_valid=1, in_sof=1, counter!=0 SHALL set sync_err and resynchronise (index 0); frame_cnt is not incremented for the truncated frame.
REQ-025 sync_err SHALL stay set until clr_err=1, clearing next edge; simultaneous set and clr_err SHALL leave it set.
REQ-026 Throughput: one pair per cycle, no backpressure; any in_valid duty cycle is legal.

Reset
REQ-027 rst=1 SHALL immediately clear counter, all pipeline taps, sel, stage_en[STAGES-1:1], out_valid, out_sof, sync_err, frame_cnt to 0.
REQ-028 Reset mid-frame SHALL discard all in-flight pairs; no out_valid until new input propagates.
REQ-029 First edge after rst deasserts SHALL accept input normally.

Verification (STAGES=4, STAGE_LAT=1, P=8)
REQ-030 Assert rst mid-stream -> all outputs 0 same cycle, stage_en[0] follows in_valid.
REQ-031 8 consecutive pairs, sof on first at cycle t -> sel[0] 0,1,0,1,0,1,0,1 from t; sel[1] 0,0,1,1,0,0,1,1 from t+1; sel[2] 0,0,0,0,1,1,1,1 from t+2; out_valid t+4..t+11; out_sof at t+4; frame_cnt=1 at t+12.
REQ-032 Same frame with in_valid every other cycle -> identical sel sequences on valid cycles, held across bubbles; frame_cnt=1.
REQ-033 sof on 6th pair -> sync_err=1 next cycle, that pair index 0, frame_cnt unchanged; clr_err pulse -> sync_err=0 next cycle.
REQ-034 Two back-to-back frames, sof only on first -> out_sof at t+4 and t+12, frame_cnt=2 at t+20.
REQ-035 FRAME_W=2, five frames -> frame_cnt 1,2,3,0,1.
